// File: rtl/mccpu_pkg.sv
// mccpu_pkg: shared definitions for the multi-cycle sequencer.
//   - state_e : sequencer state encodings. These values are exported on the
//               stage debug port, so they must stay in step with the state
//               parameters in mycpu_top.
//   - CNT_W_DEF : default width of the performance counters.
package mccpu_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_BOOT = 3'd5
    } state_e;

endpackage

// File: rtl/mccpu_if.sv
// mccpu_if: request/ready handshake between the sequencer and the
// instruction and data SRAM ports.
//   inst_req / inst_rdy : instruction fetch request and fetch-data-valid
//   data_req / data_rdy : data access request and access-complete
//   data_wr             : the outstanding data access is a write
// Handshake: a requester raises *_req and holds it, unchanged, until the
// cycle in which the responder drives *_rdy=1; that cycle completes the
// transfer. *_rdy may already be high in the first request cycle (zero
// wait). *_rdy is ignored whenever the matching *_req is low.
// Modports: master = sequencer side, slave = SRAM side.
interface mccpu_if;
    logic inst_req;
    logic inst_rdy;
    logic data_req;
    logic data_wr;
    logic data_rdy;

    modport master (output inst_req, data_req, data_wr,
                    input  inst_rdy, data_rdy);
    modport slave  (input  inst_req, data_req, data_wr,
                    output inst_rdy, data_rdy);
endinterface

// File: rtl/mccpu_perf_cnt.sv
// mccpu_perf_cnt: two free-running, wrapping performance counters.
//   clk, rst_n   : clock, asynchronous active-low reset (counters clear to 0)
//   cnt_cycle    : count this edge in cycle_cnt (sequencer outside BOOT)
//   cnt_retire   : count this edge in inst_cnt (an instruction retires)
//   cycle_cnt    : cycles counted, modulo 2^CNT_W
//   inst_cnt     : retired instructions, modulo 2^CNT_W
module mccpu_perf_cnt
    import mccpu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_cycle,
    input  logic             cnt_retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q,  inst_cnt_d;

    // Natural overflow of the adders gives the wrap.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        if (cnt_cycle)  cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (cnt_retire) inst_cnt_d  = inst_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;

endmodule

// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle sequencer for the LoongArch mini-CPU. Steps each
// instruction through BOOT/IF/ID/EXE/MEM/WB and emits one-shot write
// enables so the single-cycle datapath runs one instruction at a time.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   sram (master)        : instruction/data SRAM request/ready handshake
//   is_load, is_store    : decoded ld.w / st.w (valid EXE..WB)
//   gr_we                : instruction writes a GPR (valid EXE..WB)
//   ir_we, pc_we, rf_we  : IR latch, PC load, regfile write strobes
//   retire               : instruction completes this cycle (= pc_we)
//   stage                : current state encoding (debug/trace)
//   cycle_cnt, inst_cnt  : performance counters
// Configuration: define MCCPU_PERF_CNT_EN to build the performance counters;
// otherwise cycle_cnt and inst_cnt are tied to 0 and no counter flops exist.
module mccpu_ctrl
    import mccpu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    mccpu_if.master          sram,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             gr_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             retire,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_BOOT;
        else         state_q <= state_d;
    end

    // Every output defaults to 0, so BOOT (and therefore reset) is quiet.
    always_comb begin
        state_d       = state_q;
        sram.inst_req = 1'b0;
        sram.data_req = 1'b0;
        sram.data_wr  = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        rf_we         = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_IF;
            ST_IF: begin
                sram.inst_req = 1'b1;
                if (sram.inst_rdy) begin
                    ir_we   = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: state_d = ST_EXE;
            ST_EXE: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (gr_we) begin
                    state_d = ST_WB;
                end else begin
                    // Branch with no register write retires straight from EXE.
                    pc_we   = 1'b1;
                    state_d = ST_IF;
                end
            end
            ST_MEM: begin
                sram.data_req = 1'b1;
                sram.data_wr  = is_store;
                if (sram.data_rdy) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = ST_IF;
                    end else begin
                        // Load data is captured by the datapath on this edge.
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_IF;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign retire = pc_we;
    assign stage  = state_q;

`ifdef MCCPU_PERF_CNT_EN
    mccpu_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
        .clk        (clk),
        .rst_n      (resetn),
        .cnt_cycle  (state_q != ST_BOOT),
        .cnt_retire (pc_we),
        .cycle_cnt  (cycle_cnt),
        .inst_cnt   (inst_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign inst_cnt  = '0;
`endif

endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb_mccpu_ctrl: self-checking bench for mccpu_ctrl. A second instance with
// CNT_W=4 shares every input with the main one to exercise counter wrap.
module tb_mccpu_ctrl;
    import mccpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic is_load = 1'b0, is_store = 1'b0, gr_we = 1'b0;

    mccpu_if if_a ();
    mccpu_if if_b ();
    assign if_b.inst_rdy = if_a.inst_rdy;
    assign if_b.data_rdy = if_a.data_rdy;

    logic        ir_we, pc_we, rf_we, retire;
    logic [2:0]  stage;
    logic [31:0] cycle_cnt, inst_cnt;
    logic        ir_we4, pc_we4, rf_we4, retire4;
    logic [2:0]  stage4;
    logic [3:0]  cycle_cnt4, inst_cnt4;

    mccpu_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .sram(if_a),
        .is_load(is_load), .is_store(is_store), .gr_we(gr_we),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .retire(retire),
        .stage(stage), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    mccpu_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .sram(if_b),
        .is_load(is_load), .is_store(is_store), .gr_we(gr_we),
        .ir_we(ir_we4), .pc_we(pc_we4), .rf_we(rf_we4), .retire(retire4),
        .stage(stage4), .cycle_cnt(cycle_cnt4), .inst_cnt(inst_cnt4)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    longint exp_cycles = 0;
    longint exp_insts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_cnt(input string tag);
        longint ec, ei;
`ifdef MCCPU_PERF_CNT_EN
        ec = exp_cycles;
        ei = exp_insts;
`else
        ec = 0;
        ei = 0;
`endif
        chk({tag, ".cycle_cnt"},  64'(cycle_cnt),  64'(ec & 64'hFFFF_FFFF));
        chk({tag, ".inst_cnt"},   64'(inst_cnt),   64'(ei & 64'hFFFF_FFFF));
        chk({tag, ".cycle_cnt4"}, 64'(cycle_cnt4), 64'(ec & 64'hF));
        chk({tag, ".inst_cnt4"},  64'(inst_cnt4),  64'(ei & 64'hF));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".inst_req"}, 64'(if_a.inst_req), 0);
        chk({tag, ".data_req"}, 64'(if_a.data_req), 0);
        chk({tag, ".data_wr"},  64'(if_a.data_wr),  0);
        chk({tag, ".ir_we"},    64'(ir_we),  0);
        chk({tag, ".pc_we"},    64'(pc_we),  0);
        chk({tag, ".rf_we"},    64'(rf_we),  0);
        chk({tag, ".retire"},   64'(retire), 0);
        chk({tag, ".stage"},    64'(stage),  64'(ST_BOOT));
    endtask

    // Release reset just after a rising edge, then expect one quiet BOOT
    // cycle before the sequencer enters IF with inst_req high.
    task automatic release_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        exp_cycles = 0;
        exp_insts  = 0;
        @(negedge clk);
        #1 chk_quiet("boot");
        chk_cnt("boot");
        if_a.inst_rdy = 1'b0;
        if_a.data_rdy = 1'b0;
        gr_we = 1'b0;
        @(negedge clk);
        #1 chk("first_if.stage", 64'(stage), 64'(ST_IF));
        chk("first_if.inst_req", 64'(if_a.inst_req), 1);
        chk("first_if.ir_we", 64'(ir_we), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        logic  ld, st, gw;
        int    iw, dw;      // wait cycles on inst_rdy / data_rdy
        logic  spur;        // assert unrequested rdy lines
        int    lat, dreq, dwr, rf;
    } vec_t;

    vec_t vecs[10];

    // Drive one instruction starting at a falling edge with the DUT in IF.
    task automatic run_vec(input int i);
        vec_t v;
        int seq[$];
        int c, st_e;
        int n_dreq, n_dwr, n_rf, n_ir, n_ret;
        bit done;
        logic [31:0] e;
        v = vecs[i];
        for (int k = 0; k <= v.iw; k++) seq.push_back(int'(ST_IF));
        seq.push_back(int'(ST_ID));
        seq.push_back(int'(ST_EXE));
        if (v.ld || v.st)
            for (int k = 0; k <= v.dw; k++) seq.push_back(int'(ST_MEM));
        if (v.ld || (!v.st && v.gw)) seq.push_back(int'(ST_WB));
        exp_q.push_back({8'(v.lat), 8'(v.dreq), 8'(v.dwr), 4'(v.rf), 4'd1});
        is_load = v.ld; is_store = v.st; gr_we = v.gw;
        c = 0; done = 0;
        n_dreq = 0; n_dwr = 0; n_rf = 0; n_ir = 0; n_ret = 0;
        while (!done && c < 40) begin
            st_e = (c < seq.size()) ? seq[c] : 7;
            if (st_e == int'(ST_IF)) begin
                if_a.inst_rdy = (c == v.iw);
                if_a.data_rdy = v.spur;
            end else if (st_e == int'(ST_MEM)) begin
                if_a.inst_rdy = v.spur;
                if_a.data_rdy = (c == v.iw + 3 + v.dw);
            end else begin
                if_a.inst_rdy = v.spur;
                if_a.data_rdy = v.spur;
            end
            #1;
            chk($sformatf("%s.stage[%0d]", v.name, c), 64'(stage), 64'(st_e));
            n_dreq += int'(if_a.data_req);
            n_dwr  += int'(if_a.data_wr);
            n_rf   += int'(rf_we);
            n_ir   += int'(ir_we);
            n_ret  += int'(retire);
            if (pc_we) done = 1;
            c++;
            @(negedge clk);
        end
        if_a.inst_rdy = 1'b0;
        if_a.data_rdy = 1'b0;
        chk({v.name, ".retired_in_budget"}, 64'(done), 1);
        if (exp_q.size() == 0) begin
            chk({v.name, ".sb_nonempty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({v.name, ".latency"},    64'(c),      64'(e[31:24]));
            chk({v.name, ".data_req_n"}, 64'(n_dreq), 64'(e[23:16]));
            chk({v.name, ".data_wr_n"},  64'(n_dwr),  64'(e[15:8]));
            chk({v.name, ".rf_we_n"},    64'(n_rf),   64'(e[7:4]));
            chk({v.name, ".ir_we_n"},    64'(n_ir),   64'(e[3:0]));
        end
        chk({v.name, ".retire_n"}, 64'(n_ret), 1);
        exp_insts++;
        exp_cycles += v.lat;
        #1 chk({v.name, ".next_if"}, 64'(stage), 64'(ST_IF));
        chk_cnt(v.name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{"add",       0, 0, 1, 0, 0, 0, 4, 0, 0, 1};
        vecs[1] = '{"ld_w2",     1, 0, 1, 0, 2, 0, 7, 3, 0, 1};
        vecs[2] = '{"st",        0, 1, 0, 0, 0, 0, 4, 1, 1, 0};
        vecs[3] = '{"beq",       0, 0, 0, 0, 0, 0, 3, 0, 0, 0};
        vecs[4] = '{"add_iw2_sp",0, 0, 1, 2, 0, 1, 6, 0, 0, 1};
        vecs[5] = '{"st_dw1_sp", 0, 1, 0, 0, 1, 1, 5, 2, 2, 0};
        vecs[6] = '{"ld_sp",     1, 0, 1, 0, 0, 1, 5, 1, 0, 1};
        vecs[7] = '{"beq_iw3_sp",0, 0, 0, 3, 0, 1, 6, 0, 0, 0};
        vecs[8] = '{"st_gw",     0, 1, 1, 0, 0, 0, 4, 1, 1, 0};
        vecs[9] = '{"bl_iw1",    0, 0, 1, 1, 0, 0, 5, 0, 0, 1};

        // Reset held for 3 cycles with rdy/class inputs noisy.
        if_a.inst_rdy = 1'b1;
        if_a.data_rdy = 1'b1;
        gr_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk_quiet($sformatf("reset%0d", k));
            chk_cnt($sformatf("reset%0d", k));
        end
        release_reset();

        // st.w then beq straight out of reset: counters reach 2 and 7.
        run_vec(2);
        run_vec(3);
        for (int i = 0; i < 10; i++) run_vec(i);

        // Reset pulse while a load waits in MEM.
        is_load = 1'b1; is_store = 1'b0; gr_we = 1'b1;
        if_a.inst_rdy = 1'b1;
        if_a.data_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("mid_mem.stage", 64'(stage), 64'(ST_MEM));
        chk("mid_mem.data_req", 64'(if_a.data_req), 1);
        resetn = 1'b0;
        #1 chk("mid_mem_rst.data_req", 64'(if_a.data_req), 0);
        chk("mid_mem_rst.stage", 64'(stage), 64'(ST_BOOT));
        exp_cycles = 0;
        exp_insts  = 0;
        chk_cnt("mid_mem_rst");
        if_a.data_rdy = 1'b1;
        @(negedge clk);
        #1 chk_quiet("mid_mem_hold");
        release_reset();

        // 16 add.w: the 4-bit inst_cnt wraps back to 0 on the 16th retire.
        for (int k = 0; k < 16; k++) run_vec(0);
`ifdef MCCPU_PERF_CNT_EN
        chk("wrap.inst_cnt", 64'(inst_cnt), 16);
`else
        chk("wrap.inst_cnt", 64'(inst_cnt), 0);
`endif
        chk("wrap.inst_cnt4", 64'(inst_cnt4), 0);
        chk("sb_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
